// File: rtl/breath_pkg.sv
// Shared types and defaults for the breathing brightness-index sequencer.
package breath_pkg;

  localparam int unsigned IdxWDefault = 8;
  localparam int unsigned DivWDefault = 18;

  // Enumerator values double as the phase_o encoding seen downstream.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRise   = 3'd1,
    StHoldHi = 3'd2,
    StFall   = 3'd3,
    StHoldLo = 3'd4
  } breath_state_t;

endpackage

// File: rtl/tick_div.sv
// Step prescaler: counts 0..div and ticks on the restart cycle; freezable and clearable.
module tick_div
  import breath_pkg::*;
#(
  parameter int unsigned DIV_W = DivWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic             hit;

  // The divisor is latched at restart so a mid-interval change cannot skip the compare.
  assign hit  = (cnt_q == div_q);
  assign tick = hit && !freeze && !clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
      div_q <= div;
    end else if (!freeze) begin
      if (hit) begin
        cnt_q <= '0;
        div_q <= div;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/breath_sequencer.sv
// Triangular breathing LUT-index generator (rise, hold high, fall, hold low) with a
// valid/ready output so the PWM stage can take each new index at its own period boundary.
module breath_sequencer
  import breath_pkg::*;
#(
  parameter int unsigned IDX_W = IdxWDefault,
  parameter int unsigned DIV_W = DivWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] step_div,
  input  logic [7:0]       hold_hi,
  input  logic [7:0]       hold_lo,
  output logic [IDX_W-1:0] level_o,
  output logic             level_valid,
  input  logic             level_ready,
  output logic [2:0]       phase_o,
  output logic             cycle_done
);

  localparam logic [IDX_W-1:0] LvlPenult = {{(IDX_W-1){1'b1}}, 1'b0};
  localparam logic [IDX_W-1:0] LvlOne    = {{(IDX_W-1){1'b0}}, 1'b1};

  breath_state_t    state_q;
  logic [IDX_W-1:0] level_q;
  logic             valid_q;
  logic             done_q;
  logic [7:0]       hold_q;
  logic             stall;
  logic             accept;
  logic             clear;
  logic             tick;

  assign stall  = valid_q && !level_ready;
  assign accept = valid_q && level_ready;
  assign clear  = (state_q == StIdle) || !en;

  tick_div #(
    .DIV_W(DIV_W)
  ) u_tick_div (
    .clk   (clk),
    .rst   (rst),
    .freeze(stall),
    .clear (clear),
    .div   (step_div),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      level_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) valid_q <= 1'b0;
      if (state_q != StIdle && !en) begin
        // Dropping enable always hands a final zero downstream unless already at rest.
        state_q <= StIdle;
        level_q <= '0;
        hold_q  <= '0;
        if (level_q != '0) valid_q <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (en) state_q <= StRise;
          end
          StRise: begin
            if (tick) begin
              level_q <= level_q + 1'b1;
              valid_q <= 1'b1;
              if (level_q == LvlPenult) begin
                if (hold_hi != 8'd0) begin
                  state_q <= StHoldHi;
                  hold_q  <= hold_hi;
                end else begin
                  state_q <= StFall;
                end
              end
            end
          end
          StHoldHi: begin
            if (tick) begin
              hold_q <= hold_q - 8'd1;
              if (hold_q == 8'd1) state_q <= StFall;
            end
          end
          StFall: begin
            if (tick) begin
              level_q <= level_q - 1'b1;
              valid_q <= 1'b1;
              if (level_q == LvlOne) begin
                done_q <= 1'b1;
                if (hold_lo != 8'd0) begin
                  state_q <= StHoldLo;
                  hold_q  <= hold_lo;
                end else begin
                  state_q <= StRise;
                end
              end
            end
          end
          StHoldLo: begin
            if (tick) begin
              hold_q <= hold_q - 8'd1;
              if (hold_q == 8'd1) state_q <= StRise;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign level_o     = level_q;
  assign level_valid = valid_q;
  assign phase_o     = state_q;
  assign cycle_done  = done_q;

endmodule

// File: tb/tb_breath_sequencer.sv
// Self-checking bench: a position-in-period model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_breath_sequencer;

  localparam int MAX = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [17:0] step_div;
  logic [7:0]  hold_hi;
  logic [7:0]  hold_lo;
  logic [7:0]  level_o;
  logic        level_valid;
  logic        level_ready;
  logic [2:0]  phase_o;
  logic        cycle_done;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: m_k counts steps taken since the run started, modulo the period.
  bit m_run   = 1'b0;
  bit m_valid = 1'b0;
  bit m_done  = 1'b0;
  int m_k     = 0;
  int m_cnt   = 0;
  int m_div   = 0;
  int m_level = 0;
  int m_hh    = 0;
  int m_hl    = 0;

  int hist[1:600];

  always #5 clk = ~clk;

  breath_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .step_div   (step_div),
    .hold_hi    (hold_hi),
    .hold_lo    (hold_lo),
    .level_o    (level_o),
    .level_valid(level_valid),
    .level_ready(level_ready),
    .phase_o    (phase_o),
    .cycle_done (cycle_done)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int level_of(input int k, input int hh);
    if (k <= MAX) return k;
    if (k <= MAX + hh) return MAX;
    if (k <= 2 * MAX + hh) return 2 * MAX + hh - k;
    return 0;
  endfunction

  function automatic int phase_of(input int k, input int hh);
    if (k < MAX) return 1;
    if (k < MAX + hh) return 2;
    if (k < 2 * MAX + hh) return 3;
    return 4;
  endfunction

  task automatic model_step();
    bit stall;
    int nl;
    if (rst) begin
      m_run = 0; m_k = 0; m_cnt = 0; m_div = 0; m_level = 0; m_valid = 0; m_done = 0;
    end else begin
      stall  = m_valid && !level_ready;
      m_done = 0;
      if (!m_run) begin
        if (m_valid && level_ready) m_valid = 0;
        m_cnt = 0;
        m_div = int'(step_div);
        if (en) begin
          m_run = 1; m_k = 0; m_hh = int'(hold_hi); m_hl = int'(hold_lo);
        end
      end else if (!en) begin
        m_run = 0;
        if (m_level != 0) m_valid = 1;
        else if (level_ready) m_valid = 0;
        m_level = 0;
        m_cnt   = 0;
      end else begin
        if (m_valid && level_ready) m_valid = 0;
        if (!stall) begin
          if (m_cnt == m_div) begin
            m_cnt = 0;
            m_div = int'(step_div);
            m_k   = (m_k + 1) % (2 * MAX + m_hh + m_hl);
            nl    = level_of(m_k, m_hh);
            if (nl != m_level) begin
              m_valid = 1;
              m_done  = (nl == 0);
            end
            m_level = nl;
          end else begin
            m_cnt++;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("level", level_o, m_level);
    check("valid", level_valid, m_valid);
    check("phase", phase_o, m_run ? phase_of(m_k, m_hh) : 0);
    check("done", cycle_done, m_done);
  end

  task automatic wait_for(input int lvl, input int ph, input int budget, input string name);
    int n;
    n = 0;
    while (!(level_o == 8'(lvl) && (ph < 0 || phase_o == 3'(ph))) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: level %0d not reached in %0d cycles, got level %0d", name, lvl,
               budget, level_o);
    end
  endtask

  initial begin
    int done_cnt;
    int hi_xfers;
    int n255;
    int nzero;

    rst = 1'b1; en = 1'b0; step_div = '0; hold_hi = '0; hold_lo = '0; level_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_level", level_o, 0);
    check("reset_valid", level_valid, 0);
    check("reset_phase", phase_o, 0);
    check("reset_done", cycle_done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Prescaler 3, no holds: first level after 5 clocks, one done per 2040 clocks.
    step_div = 18'd3;
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) check("a_phase_rise", phase_o, 1);
      if (i < 5) check("a_pre_first", level_o, 0);
      else check("a_first_level", level_o, 1);
    end
    done_cnt = 0;
    hi_xfers = 0;
    for (int i = 6; i <= 2050; i++) begin
      @(negedge clk);
      if (cycle_done) done_cnt++;
      if (level_valid && level_ready && level_o == 8'd255) hi_xfers++;
    end
    check("a_done_pulses", done_cnt, 1);
    check("a_max_xfers", hi_xfers, 1);
    en = 1'b0;
    repeat (4) @(negedge clk);

    // Holds 5/2 at one step per clock: 255 dwells 6 clocks, 0 dwells 3.
    step_div = '0; hold_hi = 8'd5; hold_lo = 8'd2;
    en = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      hist[i] = int'(level_o);
    end
    n255 = 0;
    nzero = 0;
    for (int i = 1; i <= 600; i++) begin
      if (hist[i] == 255) n255++;
      if (i >= 262 && hist[i] == 0) nzero++;
    end
    check("b_max_dwell", n255, 6);
    check("b_first_255", hist[256], 255);
    check("b_after_hold", hist[262], 254);
    check("b_zero_dwell", nzero, 3);
    check("b_restart_one", hist[519], 1);
    en = 1'b0; hold_hi = '0; hold_lo = '0;
    repeat (4) @(negedge clk);

    // Downstream stalls for 100 clocks: level frozen, then strictly +1.
    en = 1'b1;
    repeat (11) @(negedge clk);
    check("c_level10", level_o, 10);
    level_ready = 1'b0;
    repeat (100) @(negedge clk);
    check("c_frozen", level_o, 10);
    check("c_frozen_valid", level_valid, 1);
    level_ready = 1'b1;
    @(negedge clk);
    check("c_next11", level_o, 11);
    @(negedge clk);
    check("c_next12", level_o, 12);

    // Direct RISE->FALL turnaround, then enable drop mid-FALL with ready low.
    wait_for(255, -1, 400, "d_wait255");
    check("d_phase_at_max", phase_o, 3);
    @(negedge clk);
    check("d_after_max", level_o, 254);
    wait_for(200, 3, 400, "d_wait200");
    level_ready = 1'b0;
    en = 1'b0;
    @(negedge clk);
    check("d_drop_level", level_o, 0);
    check("d_drop_valid", level_valid, 1);
    check("d_drop_phase", phase_o, 0);
    repeat (5) @(negedge clk);
    check("d_pending_valid", level_valid, 1);
    level_ready = 1'b1;
    @(negedge clk);
    check("d_cleared_valid", level_valid, 0);
    repeat (2) @(negedge clk);

    // Reset at level 37 in RISE, enable held: level 1 returns step_div+2 clocks later.
    step_div = 18'd2;
    en = 1'b1;
    wait_for(37, 1, 400, "e_wait37");
    rst = 1'b1;
    @(negedge clk);
    check("e_rst_level", level_o, 0);
    check("e_rst_valid", level_valid, 0);
    check("e_rst_phase", phase_o, 0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) check("e_pre_first", level_o, 0);
      else check("e_first_level", level_o, 1);
    end
    repeat (50) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
